frame_write_arbiter: RTL and testbench

Shares the single write port of the 40x30 text frame buffer between NREQ character producers, such as the cycle printer, the keyboard echo and the status line. Arbitration is round-robin with a valid/ready handshake.
- Contains a clear-screen sequencer that takes priority and sweeps every cell to character 0.
- Sits between the producers and the frame memory/VGA text generator.
- Drives frame_x/frame_y/frame_char/frame_we on behalf of all producers.

---
 rtl/frame_pkg.sv | 27 ++
 rtl/frame_write_arbiter_if.sv | 35 +++
 rtl/frame_write_arbiter_rr_arbiter.sv | 34 +++
 rtl/frame_write_arbiter.sv | 153 +++++++++++++++
 tb/tb_frame_write_arbiter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_pkg.sv
// Shared constants and types for the text frame-buffer write path.
// Geometry, special character codes, write record and arbiter state.
package frame_pkg;

    localparam int COLS       = 40;
    localparam int ROWS       = 30;
    localparam int CHAR_W     = 6;
    localparam int CHAR_BLANK = 0;
    localparam int CHAR_ARROW = 37;

    typedef struct packed {
        logic [5:0]        x;
        logic [5:0]        y;
        logic [CHAR_W-1:0] ch;
    } frame_wr_t;

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } arb_state_t;

    // Index width for an n-entry selector, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_write_arbiter_if.sv
// Producer request bundle plus frame-buffer write port (FRAME_ARB_LOCK_EN adds req_lock).
// master = producers/frame memory side, slave = arbiter side.
interface frame_write_arbiter_if #(
    parameter int NREQ   = 3,
    parameter int CHAR_W = frame_pkg::CHAR_W
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*6-1:0]      req_x;
    logic [NREQ*6-1:0]      req_y;
    logic [NREQ*CHAR_W-1:0] req_char;
`ifdef FRAME_ARB_LOCK_EN
    logic [NREQ-1:0]        req_lock;
`endif
    logic                   frame_we;
    logic [5:0]             frame_x;
    logic [5:0]             frame_y;
    logic [CHAR_W-1:0]      frame_char;

    modport master (
`ifdef FRAME_ARB_LOCK_EN
        output req_lock,
`endif
        output req_valid, req_x, req_y, req_char,
        input  req_ready, frame_we, frame_x, frame_y, frame_char
    );

    modport slave (
`ifdef FRAME_ARB_LOCK_EN
        input  req_lock,
`endif
        input  req_valid, req_x, req_y, req_char,
        output req_ready, frame_we, frame_x, frame_y, frame_char
    );
endinterface

// File: rtl/frame_write_arbiter_rr_arbiter.sv
// Round-robin one-hot grant: search starts one past ptr and takes the first request.
// Latency: purely combinational. Backpressure: none, grant simply follows req.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int PW   = frame_pkg::idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   gnt_idx,
    output logic            gnt_vld
);

    int idx;

    // Walk from farthest to nearest so the nearest valid request is written last.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_idx  = PW'(idx);
                gnt_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_write_arbiter.sv
// Shares the frame-buffer write port among NREQ producers (round-robin) with a clear sweep (FRAME_ARB_LOCK_EN: sticky grant).
// Latency: one cycle from handshake to frame_we. Backpressure: req_ready one-hot, zero while clearing or clear_req sampled.
module frame_write_arbiter #(
    parameter int NREQ   = 3,
    parameter int COLS   = frame_pkg::COLS,
    parameter int ROWS   = frame_pkg::ROWS,
    parameter int CHAR_W = frame_pkg::CHAR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    frame_write_arbiter_if.slave  bus,
    input  logic                  clear_req,
    output logic                  clear_busy,
    output logic [2:0]            grant_id,
    output logic                  coord_err
);
    import frame_pkg::*;

    localparam int         PW   = idx_w(NREQ);
    localparam logic [5:0] XMAX = 6'(COLS - 1);
    localparam logic [5:0] YMAX = 6'(ROWS - 1);

    arb_state_t        state_q, state_d;
    logic [PW-1:0]     ptr_q;
    logic [5:0]        cx_q, cy_q;
    logic              clear_start, clear_last, arb_en;
    logic [NREQ-1:0]   rr_gnt, gnt_oh;
    logic [PW-1:0]     rr_idx, gnt_idx;
    logic              rr_vld, gnt_any, gnt_vld;
    logic [5:0]        sel_x, sel_y;
    logic [CHAR_W-1:0] sel_char;
    logic              sel_ok;
    logic              frame_we_q, coord_err_q;
    logic [5:0]        frame_x_q, frame_y_q;
    logic [CHAR_W-1:0] frame_char_q;
    logic [2:0]        grant_id_q;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
        .req     (bus.req_valid),
        .ptr     (ptr_q),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx),
        .gnt_vld (rr_vld)
    );

`ifdef FRAME_ARB_LOCK_EN
    logic granted_q, lock_hit;

    // ptr_q always holds the last granted index; granted_q says that grant was last cycle.
    assign lock_hit = granted_q & bus.req_lock[ptr_q] & bus.req_valid[ptr_q];
    assign gnt_oh   = lock_hit ? (NREQ'(1) << ptr_q) : rr_gnt;
    assign gnt_idx  = lock_hit ? ptr_q : rr_idx;
    assign gnt_any  = lock_hit | rr_vld;

    always_ff @(posedge clk) begin
        if (reset) granted_q <= 1'b0;
        else       granted_q <= gnt_vld;
    end
`else
    assign gnt_oh  = rr_gnt;
    assign gnt_idx = rr_idx;
    assign gnt_any = rr_vld;
`endif

    assign clear_start = (state_q == ARB) & clear_req;
    assign arb_en      = (state_q == ARB) & ~clear_req;
    assign gnt_vld     = arb_en & gnt_any;
    assign clear_last  = (cx_q == XMAX) & (cy_q == YMAX);

    always_ff @(posedge clk) begin
        if (reset) state_q <= ARB;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:     if (clear_req)  state_d = CLEAR;
            CLEAR:   if (clear_last) state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        clear_busy    = (state_q == CLEAR);
        bus.req_ready = arb_en ? gnt_oh : '0;
    end

    always_comb begin
        sel_x    = '0;
        sel_y    = '0;
        sel_char = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_oh[i]) begin
                sel_x    = bus.req_x[6*i +: 6];
                sel_y    = bus.req_y[6*i +: 6];
                sel_char = bus.req_char[CHAR_W*i +: CHAR_W];
            end
        end
        sel_ok = (sel_x <= XMAX) & (sel_y <= YMAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q        <= PW'(NREQ - 1);
            grant_id_q   <= '0;
            frame_we_q   <= 1'b0;
            frame_x_q    <= '0;
            frame_y_q    <= '0;
            frame_char_q <= '0;
            coord_err_q  <= 1'b0;
            cx_q         <= '0;
            cy_q         <= '0;
        end else begin
            frame_we_q <= 1'b0;
            if (clear_start) begin
                cx_q <= '0;
                cy_q <= '0;
            end else if (state_q == CLEAR) begin
                frame_we_q   <= 1'b1;
                frame_x_q    <= cx_q;
                frame_y_q    <= cy_q;
                frame_char_q <= CHAR_W'(CHAR_BLANK);
                if (cx_q == XMAX) begin
                    cx_q <= '0;
                    cy_q <= (cy_q == YMAX) ? 6'd0 : cy_q + 6'd1;
                end else begin
                    cx_q <= cx_q + 6'd1;
                end
            end else if (gnt_vld) begin
                ptr_q      <= gnt_idx;
                grant_id_q <= 3'(gnt_idx);
                // Out-of-range cells are accepted from the producer but never written.
                if (sel_ok) begin
                    frame_we_q   <= 1'b1;
                    frame_x_q    <= sel_x;
                    frame_y_q    <= sel_y;
                    frame_char_q <= sel_char;
                end else begin
                    coord_err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.frame_we   = frame_we_q;
    assign bus.frame_x    = frame_x_q;
    assign bus.frame_y    = frame_y_q;
    assign bus.frame_char = frame_char_q;
    assign grant_id       = grant_id_q;
    assign coord_err      = coord_err_q;

endmodule

// File: tb/tb_frame_write_arbiter.sv
// Bench for frame_write_arbiter: directed scenarios plus random traffic against a cell-index reference model.
// Optional FRAME_ARB_LOCK_EN scenario is compiled in only when the macro is defined.
module tb_frame_write_arbiter;
    import frame_pkg::*;

    localparam int NREQ  = 3;
    localparam int CELLS = COLS * ROWS;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear_req;
    logic       clear_busy;
    logic       coord_err;
    logic [2:0] grant_id;

    frame_write_arbiter_if #(.NREQ(NREQ), .CHAR_W(CHAR_W)) bus ();

    frame_write_arbiter #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .grant_id   (grant_id),
        .coord_err  (coord_err)
    );

    always #5 clk = ~clk;

    logic [NREQ-1:0] vld;
    frame_wr_t       pay [NREQ];
`ifdef FRAME_ARB_LOCK_EN
    logic [NREQ-1:0] lock;
    assign bus.req_lock = lock;
`endif
    assign bus.req_valid = vld;

    always_comb begin
        bus.req_x    = '0;
        bus.req_y    = '0;
        bus.req_char = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_x[6*i +: 6]               = pay[i].x;
            bus.req_y[6*i +: 6]               = pay[i].y;
            bus.req_char[CHAR_W*i +: CHAR_W]  = pay[i].ch;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a linear cell index for the sweep, plain modulo search for round-robin.
    bit              m_clearing;
    int              m_cell, m_ptr, m_gid, m_last, m_g;
    bit              m_err, m_we;
    int              m_x, m_y, m_ch;
    logic [NREQ-1:0] m_xfer, exp_ready;

    logic            obs_we, obs_busy;
    logic [5:0]      obs_x, obs_y;
    logic [NREQ-1:0] obs_ready;

    task automatic model_reset();
        m_clearing = 0; m_cell = 0; m_ptr = NREQ - 1; m_gid = 0; m_last = -1;
        m_err = 0; m_we = 0; m_x = 0; m_y = 0; m_ch = 0; m_xfer = '0;
    endtask

    task automatic model_comb();
        m_g = -1;
        if (!m_clearing && !clear_req) begin
`ifdef FRAME_ARB_LOCK_EN
            if (m_last >= 0 && lock[m_last] && vld[m_last]) m_g = m_last;
`endif
            for (int k = 1; k <= NREQ; k++)
                if (m_g < 0 && vld[(m_ptr + k) % NREQ]) m_g = (m_ptr + k) % NREQ;
        end
        exp_ready = (m_g >= 0) ? (NREQ'(1) << m_g) : '0;
    endtask

    task automatic model_seq();
        m_xfer = '0;
        if (reset) begin
            model_reset();
        end else if (m_clearing) begin
            m_we = 1; m_x = m_cell % COLS; m_y = m_cell / COLS; m_ch = CHAR_BLANK;
            m_cell++;
            if (m_cell == CELLS) m_clearing = 0;
            m_last = -1;
        end else if (clear_req) begin
            m_clearing = 1; m_cell = 0; m_we = 0; m_last = -1;
        end else if (m_g >= 0) begin
            m_xfer[m_g] = 1'b1;
            m_ptr = m_g; m_gid = m_g; m_last = m_g;
            if (int'(pay[m_g].x) < COLS && int'(pay[m_g].y) < ROWS) begin
                m_we = 1; m_x = pay[m_g].x; m_y = pay[m_g].y; m_ch = pay[m_g].ch;
            end else begin
                m_we = 0; m_err = 1;
            end
        end else begin
            m_we = 0; m_last = -1;
        end
    endtask

    // Called just after a negedge with inputs applied; returns at the next negedge.
    task automatic step();
        #1;
        model_comb();
        obs_we = bus.frame_we; obs_x = bus.frame_x; obs_y = bus.frame_y;
        obs_busy = clear_busy; obs_ready = bus.req_ready;
        chk("req_ready",  32'(bus.req_ready),  32'(exp_ready));
        chk("frame_we",   32'(bus.frame_we),   32'(m_we));
        chk("frame_x",    32'(bus.frame_x),    32'(m_x));
        chk("frame_y",    32'(bus.frame_y),    32'(m_y));
        chk("frame_char", 32'(bus.frame_char), 32'(m_ch));
        chk("clear_busy", 32'(clear_busy),     32'(m_clearing));
        chk("coord_err",  32'(coord_err),      32'(m_err));
        chk("grant_id",   32'(grant_id),       32'(m_gid));
        @(posedge clk);
        model_seq();
        @(negedge clk);
    endtask

    // Pulses clear_req, then follows the sweep; stop_at>0 returns after that many writes.
    task automatic run_clear(input int stop_at, input logic [NREQ-1:0] first_rdy);
        bit prev_busy, done;
        int cnt, lx, ly;
        clear_req = 1'b1;
        step();
        chk("clr_req_rdy", 32'(obs_ready), 32'd0);
        clear_req = 1'b0;
        prev_busy = 0; done = 0; cnt = 0; lx = -1; ly = -1;
        for (int b = 0; b < CELLS + 100 && !done; b++) begin
            step();
            if (prev_busy && obs_we) begin
                cnt++;
                if (cnt == 1) begin
                    chk("clr_first_x", 32'(obs_x), 32'd0);
                    chk("clr_first_y", 32'(obs_y), 32'd0);
                end
                lx = obs_x; ly = obs_y;
            end
            if (stop_at > 0 && cnt == stop_at) begin
                done = 1;
            end else if (prev_busy && !obs_busy) begin
                done = 1;
                chk("clr_count",   32'(cnt), 32'(CELLS));
                chk("clr_last_x",  32'(lx),  32'(COLS - 1));
                chk("clr_last_y",  32'(ly),  32'(ROWS - 1));
                chk("clr_post_rdy", 32'(obs_ready), 32'(first_rdy));
            end
            prev_busy = obs_busy;
        end
        chk("clr_bounded", 32'(done), 32'd1);
    endtask

    int rr_seq [6] = '{1, 2, 4, 1, 2, 4};
    int lk_seq [5] = '{4, 4, 4, 1, 2};

    initial begin
        reset = 1'b1; clear_req = 1'b0; vld = '0;
        for (int i = 0; i < NREQ; i++) pay[i] = '0;
`ifdef FRAME_ARB_LOCK_EN
        lock = '0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Idle after reset.
        repeat (10) step();

        // Three continuous producers rotate 0,1,2.
        for (int i = 0; i < NREQ; i++) begin
            pay[i].x = 6'(i); pay[i].y = 6'd5; pay[i].ch = CHAR_W'(i + 1);
        end
        vld = 3'b111;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_seq", 32'(obs_ready), 32'(rr_seq[k]));
        end
        vld = '0;
        step();

        // Out-of-range column is accepted but dropped.
        pay[1].x = 6'd40; pay[1].y = 6'd3; pay[1].ch = 6'd7;
        vld = 3'b010;
        step();
        chk("oor_ready", 32'(obs_ready), 32'd2);
        vld = '0;
        step();
        chk("oor_no_we", 32'(obs_we), 32'd0);
        chk("oor_err", 32'(coord_err), 32'd1);
        repeat (3) step();
        chk("oor_err_sticky", 32'(coord_err), 32'd1);

        // Clear while producer 0 waits; it is served right after.
        pay[0].x = 6'd7; pay[0].y = 6'd7; pay[0].ch = 6'd9;
        vld = 3'b001;
        run_clear(0, 3'b001);
        vld = '0;
        step();

        // Reset in the middle of a sweep, then a fresh sweep.
        run_clear(500, 3'b000);
        reset = 1'b1;
        step();
        reset = 1'b0;
        pay[2].x = 6'd3; pay[2].y = 6'd4; pay[2].ch = 6'd5;
        vld = 3'b100;
        step();
        chk("rst_busy", 32'(obs_busy), 32'd0);
        chk("rst_we", 32'(obs_we), 32'd0);
        chk("rst_arb_rdy", 32'(obs_ready), 32'd4);
        vld = '0;
        step();
        run_clear(0, 3'b000);

`ifdef FRAME_ARB_LOCK_EN
        for (int i = 0; i < NREQ; i++) begin
            pay[i].x = 6'(10 + i); pay[i].y = 6'd1; pay[i].ch = CHAR_W'(CHAR_ARROW);
        end
        vld = 3'b100; lock = 3'b100;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("lock_seq", 32'(obs_ready), 32'(lk_seq[k]));
            vld = 3'b111;
            if (k == 2) lock = '0;
        end
        vld = 3'b100; lock = 3'b100;
        step();
        vld = 3'b111;
        run_clear(0, 3'b001);
        vld = '0; lock = '0;
        step();
`endif

        // Random traffic with occasional clears.
        for (int c = 0; c < 2000; c++) begin
            clear_req = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!vld[i] || m_xfer[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        vld[i]     = 1'b1;
                        pay[i].x   = 6'($urandom_range(0, 44));
                        pay[i].y   = 6'($urandom_range(0, 32));
                        pay[i].ch  = CHAR_W'($urandom);
                    end else begin
                        vld[i] = 1'b0;
                    end
                end
`ifdef FRAME_ARB_LOCK_EN
                lock[i] = ($urandom_range(0, 3) == 0);
`endif
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

endmodule
